seg7_capture: RTL

Seven-segment readback decoder and sequence checker for the two-digit BCD counter display path. It samples the active-low units and tens segment buses, waits for them to be stable, and decodes them back to BCD. It flags patterns that are not legal digits and, when compiled in, checks that successive accepted values step by +1 modulo 100. It sits beside the display drivers as an on-board self-check, driven from the same board clock.

---
 rtl/seg7_capture_if.sv | 27 ++
 rtl/seg7_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture_if.sv
`default_nettype none
//==============================================================================
// Module : seg7_capture_if
// Desc   : Segment-bus sample inputs and decoded readback outputs of seg7_capture.
// Rev    : 1.0  initial release
//==============================================================================
interface seg7_capture_if;
    logic [6:0] seg7_in;
    logic [6:0] seg7_tens_in;
    logic [3:0] bcd_units;
    logic [3:0] bcd_tens;
    logic       value_valid;
    logic       invalid_code;
    logic       seq_error;
    logic [7:0] error_count;

    modport master (
        output seg7_in, seg7_tens_in,
        input  bcd_units, bcd_tens, value_valid, invalid_code, seq_error, error_count
    );

    modport slave (
        input  seg7_in, seg7_tens_in,
        output bcd_units, bcd_tens, value_valid, invalid_code, seq_error, error_count
    );
endinterface
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
//==============================================================================
// Module : seg7_capture
// Desc   : Two-digit seven-segment readback decoder with stability filter, illegal
//          pattern detection and optional +1 mod 100 sequence check.
// Option : define SEG7_SEQ_CHECK_EN to build the sequence checker.
// Rev    : 1.0  initial release
//==============================================================================
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    seg7_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0]  c_stable     = 8'(STABLE_CYCLES);
    // Bit 14 set can never match a sampled {tens, units} pair.
    localparam logic [14:0] c_impossible = 15'h4000;

    // Returns {illegal, digit}; blank decodes to digit 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h7F:   r = 5'h0F;
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    state_t      state_q,  state_d;
    logic [14:0] samp_q,   samp_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [14:0] acc_q,    acc_d;
    logic [14:0] rej_q,    rej_d;
    logic [3:0]  bcd_units_q, bcd_units_d;
    logic [3:0]  bcd_tens_q,  bcd_tens_d;
    logic        valid_q,  valid_d;
    logic        inv_q,    inv_d;
    logic [7:0]  err_q,    err_d;

    logic [14:0] w_pair;
    logic        w_same;
    logic        w_new;
    logic        w_accept;
    logic [4:0]  w_dt;
    logic [4:0]  w_du;
    logic        w_illegal;
    logic        w_event;

`ifdef SEG7_SEQ_CHECK_EN
    logic        have_prev_q, have_prev_d;
    logic [6:0]  prev_q,      prev_d;
    logic        seq_q,       seq_d;
    logic [6:0]  w_tens_val;
    logic [6:0]  w_val;
    logic [6:0]  w_prev_inc;
`endif

    assign w_pair    = {1'b0, bus.seg7_tens_in, bus.seg7_in};
    assign w_same    = (samp_q == w_pair);
    assign w_new     = (w_pair != acc_q) && (w_pair != rej_q);
    assign w_dt      = decode(bus.seg7_tens_in);
    assign w_du      = decode(bus.seg7_in);
    assign w_illegal = w_dt[4] | w_du[4];
    // Acceptance lands on the edge where the counter would reach STABLE_CYCLES.
    assign w_accept  = (state_q == ST_SETTLE) && w_new && w_same && (cnt_q == c_stable - 8'd1);

`ifdef SEG7_SEQ_CHECK_EN
    assign w_tens_val = (w_dt[3:0] == 4'hF) ? 7'd0 : {3'b000, w_dt[3:0]};
    assign w_val      = w_tens_val * 7'd10 + {3'b000, w_du[3:0]};
    assign w_prev_inc = (prev_q == 7'd99) ? 7'd0 : prev_q + 7'd1;
`endif

    always_comb begin
        state_d     = state_q;
        samp_d      = w_pair;
        acc_d       = acc_q;
        rej_d       = rej_q;
        bcd_units_d = bcd_units_q;
        bcd_tens_d  = bcd_tens_q;
        valid_d     = 1'b0;
        inv_d       = 1'b0;
        if (!w_same) begin
            cnt_d = 8'd0;
        end else if (cnt_q == c_stable) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            ST_EMPTY, ST_HOLD: begin
                if (w_new) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_accept || !w_new) state_d = ST_HOLD;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (w_accept) begin
            if (w_illegal) begin
                inv_d = 1'b1;
                rej_d = w_pair;
            end else begin
                valid_d     = 1'b1;
                acc_d       = w_pair;
                bcd_tens_d  = w_dt[3:0];
                bcd_units_d = w_du[3:0];
            end
        end
    end

`ifdef SEG7_SEQ_CHECK_EN
    always_comb begin
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        seq_d       = 1'b0;
        if (w_accept) begin
            if (w_illegal || (w_du[3:0] == 4'hF)) begin
                have_prev_d = 1'b0;
            end else begin
                seq_d       = have_prev_q && (w_val != w_prev_inc);
                prev_d      = w_val;
                have_prev_d = 1'b1;
            end
        end
    end
    assign w_event = inv_d | seq_d;
`else
    assign w_event = inv_d;
`endif

    assign err_d = (w_event && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            samp_q      <= c_impossible;
            cnt_q       <= 8'd0;
            acc_q       <= c_impossible;
            rej_q       <= c_impossible;
            bcd_units_q <= 4'hF;
            bcd_tens_q  <= 4'hF;
            valid_q     <= 1'b0;
            inv_q       <= 1'b0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            rej_q       <= rej_d;
            bcd_units_q <= bcd_units_d;
            bcd_tens_q  <= bcd_tens_d;
            valid_q     <= valid_d;
            inv_q       <= inv_d;
            err_q       <= err_d;
        end
    end

`ifdef SEG7_SEQ_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            have_prev_q <= 1'b0;
            prev_q      <= 7'd0;
            seq_q       <= 1'b0;
        end else begin
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            seq_q       <= seq_d;
        end
    end
    assign bus.seq_error = seq_q;
`else
    assign bus.seq_error = 1'b0;
`endif

    assign bus.bcd_units    = bcd_units_q;
    assign bus.bcd_tens     = bcd_tens_q;
    assign bus.value_valid  = valid_q;
    assign bus.invalid_code = inv_q;
    assign bus.error_count  = err_q;

endmodule
`default_nettype wire
